mem_access_unit: RTL and testbench

//   Initiator-side load/store controller for the byte-addressable, big-endian data memory.

---
 rtl/mem_access_unit.sv | 149 ++++++++++++++
 tb/tb_mem_access_unit.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store controller for a byte-addressable big-endian data memory.
// One request in flight; checks range/alignment and formats load data.
module mem_access_unit #(
   parameter int unsigned MEM_BYTES = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic        req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic        resp_error,
   output logic [31:0] resp_rdata,
   output logic [1:0]  mem_read,
   output logic [1:0]  mem_write,
   output logic [31:0] mem_address,
   output logic [31:0] mem_word_in,
   input  logic [31:0] mem_word_out
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR,
      S_RD,
      S_RD_WAIT,
      S_RESP
   } state_t;

   state_t      state_q, state_d;
   logic        size_q, size_d;
   logic        signed_q, signed_d;
   logic        err_q, err_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] word_in_q, word_in_d;
   logic [31:0] rdata_q, rdata_d;

   logic [32:0] req_end;
   logic        req_err;
   logic [31:0] wdata_fmt;
   logic [31:0] load_fmt;

   always_comb begin
      req_end   = {1'b0, req_addr} + (req_size ? 33'd4 : 33'd1);
      req_err   = (req_size && (req_addr[1:0] != 2'b00))
                  || (req_end > 33'(MEM_BYTES));
      wdata_fmt = req_size ? req_wdata : {24'b0, req_wdata[7:0]};
   end

   always_comb begin
      if (size_q) begin
         load_fmt = mem_word_out;
      end else if (signed_q) begin
         load_fmt = {{24{mem_word_out[7]}}, mem_word_out[7:0]};
      end else begin
         load_fmt = {24'b0, mem_word_out[7:0]};
      end
   end

   // Rejected requests still pass through WR/RD with strobes gated off,
   // so every store or error answers two cycles after acceptance.
   always_comb begin
      state_d   = state_q;
      size_d    = size_q;
      signed_d  = signed_q;
      err_d     = err_q;
      addr_d    = addr_q;
      word_in_d = word_in_q;
      rdata_d   = rdata_q;
      unique case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               size_d   = req_size;
               signed_d = req_signed;
               err_d    = req_err;
               addr_d   = req_addr;
               if (req_write && !req_err) begin
                  word_in_d = wdata_fmt;
               end
               if (req_write || req_err) begin
                  rdata_d = 32'b0;
               end
               state_d = req_write ? S_WR : S_RD;
            end
         end
         S_WR: begin
            state_d = S_RESP;
         end
         S_RD: begin
            state_d = err_q ? S_RESP : S_RD_WAIT;
         end
         S_RD_WAIT: begin
            rdata_d = load_fmt;
            state_d = S_RESP;
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         size_q    <= 1'b0;
         signed_q  <= 1'b0;
         err_q     <= 1'b0;
         addr_q    <= 32'b0;
         word_in_q <= 32'b0;
         rdata_q   <= 32'b0;
      end else begin
         state_q   <= state_d;
         size_q    <= size_d;
         signed_q  <= signed_d;
         err_q     <= err_d;
         addr_q    <= addr_d;
         word_in_q <= word_in_d;
         rdata_q   <= rdata_d;
      end
   end

   // Strobes decode straight from state so reset kills them at once.
   always_comb begin
      mem_write = 2'b00;
      mem_read  = 2'b00;
      if (state_q == S_WR && !err_q) begin
         mem_write = size_q ? 2'b11 : 2'b01;
      end
      if (state_q == S_RD && !err_q) begin
         mem_read = size_q ? 2'b11 : 2'b01;
      end
   end

   always_comb begin
      req_ready   = (state_q == S_IDLE);
      resp_valid  = (state_q == S_RESP);
      resp_error  = (state_q == S_RESP) && err_q;
      resp_rdata  = rdata_q;
      mem_address = addr_q;
      mem_word_in = word_in_q;
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: big-endian memory model, reference model,
// directed and random load/store traffic.
module tb_mem_access_unit;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic        req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_error;
   logic [31:0] resp_rdata;
   logic [1:0]  mem_read;
   logic [1:0]  mem_write;
   logic [31:0] mem_address;
   logic [31:0] mem_word_in;
   logic [31:0] mem_word_out;

   int checks = 0;
   int errors = 0;

   logic       mem_init;
   logic [7:0] mem [0:63];
   logic [7:0] ref_mem [0:63];

   mem_access_unit #(.MEM_BYTES(64)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_size     (req_size),
      .req_signed   (req_signed),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_error   (resp_error),
      .resp_rdata   (resp_rdata),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .mem_address  (mem_address),
      .mem_word_in  (mem_word_in),
      .mem_word_out (mem_word_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Attached memory: big-endian, read data registered at the strobe edge.
   initial mem_word_out = 32'b0;
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 64; i++) mem[i] <= 8'(i * 37 + 11);
      end else begin
         if (mem_write == 2'b11 && mem_address <= 32'd60) begin
            for (int k = 0; k < 4; k++)
               mem[mem_address[5:0] + k] <= mem_word_in[8*(3-k) +: 8];
         end else if (mem_write == 2'b01 && mem_address <= 32'd63) begin
            mem[mem_address[5:0]] <= mem_word_in[7:0];
         end
         if (mem_read == 2'b11 && mem_address <= 32'd60) begin
            mem_word_out <= {mem[mem_address[5:0]],
                             mem[mem_address[5:0] + 1],
                             mem[mem_address[5:0] + 2],
                             mem[mem_address[5:0] + 3]};
         end else if (mem_read == 2'b01 && mem_address <= 32'd63) begin
            mem_word_out <= ($urandom() & 32'hFFFFFF00)
                            | {24'h0, mem[mem_address[5:0]]};
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: byte array plus the addressing and extension rules.
   task automatic model(input bit w, input bit sz, input bit sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output bit e, output logic [31:0] rd);
      longint unsigned last;
      logic [7:0] b;
      last = 64'(a) + (sz ? 64'd4 : 64'd1);
      e = (sz && a[1:0] != 2'b00) || (last > 64);
      rd = 32'b0;
      if (!e) begin
         if (w) begin
            if (sz) begin
               for (int k = 0; k < 4; k++) ref_mem[a + k] = wd[8*(3-k) +: 8];
            end else begin
               ref_mem[a] = wd[7:0];
            end
         end else if (sz) begin
            rd = {ref_mem[a], ref_mem[a + 1], ref_mem[a + 2], ref_mem[a + 3]};
         end else begin
            b = ref_mem[a];
            rd = (sg && b[7]) ? {24'hFFFFFF, b} : {24'h000000, b};
         end
      end
   endtask

   task automatic txn(input bit w, input bit sz, input bit sg,
                      input logic [31:0] a, input logic [31:0] wd,
                      input string tag, output logic [31:0] rd_o);
      bit e;
      logic [31:0] exp_rd;
      int lat_exp, lat, nwr, nrd, ovl;
      logic [1:0] wr_code, rd_code;
      logic [31:0] wr_addr, rd_addr, wr_data;
      logic got_err;
      logic [31:0] got_rd;
      lat = 0; nwr = 0; nrd = 0; ovl = 0;
      wr_code = 2'b00; rd_code = 2'b00;
      wr_addr = 32'b0; rd_addr = 32'b0; wr_data = 32'b0;
      got_err = 1'b0; got_rd = 32'b0;
      @(negedge clk);
      chk({tag, "_ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
      req_addr = a; req_wdata = wd;
      model(w, sz, sg, a, wd, e, exp_rd);
      lat_exp = (e || w) ? 2 : 3;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_write = 1'($urandom()); req_size = 1'($urandom());
      req_signed = 1'($urandom()); req_addr = $urandom();
      req_wdata = $urandom();
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (mem_write != 2'b00) begin
            nwr++; wr_code = mem_write; wr_addr = mem_address;
            wr_data = mem_word_in;
         end
         if (mem_read != 2'b00) begin
            nrd++; rd_code = mem_read; rd_addr = mem_address;
         end
         if (mem_write != 2'b00 && mem_read != 2'b00) ovl++;
         if (resp_valid) begin
            lat = c; got_err = resp_error; got_rd = resp_rdata;
            break;
         end
      end
      chk({tag, "_lat"}, 32'(lat), 32'(lat_exp));
      chk({tag, "_err"}, 32'(got_err), 32'(e));
      chk({tag, "_rdata"}, got_rd, exp_rd);
      chk({tag, "_nwr"}, 32'(nwr), (w && !e) ? 32'd1 : 32'd0);
      chk({tag, "_nrd"}, 32'(nrd), (!w && !e) ? 32'd1 : 32'd0);
      chk({tag, "_ovl"}, 32'(ovl), 32'd0);
      if (nwr != 0) begin
         chk({tag, "_wcode"}, 32'(wr_code), sz ? 32'd3 : 32'd1);
         chk({tag, "_waddr"}, wr_addr, a);
         chk({tag, "_wdata"}, wr_data, sz ? wd : {24'h0, wd[7:0]});
      end
      if (nrd != 0) begin
         chk({tag, "_rcode"}, 32'(rd_code), sz ? 32'd3 : 32'd1);
         chk({tag, "_raddr"}, rd_addr, a);
      end
      rd_o = got_rd;
   endtask

   bit          qw [4];
   bit          qs [4];
   bit          qg [4];
   logic [31:0] qa [4];
   logic [31:0] qd [4];
   bit          qe [4];
   logic [31:0] qr [4];

   initial begin
      logic [31:0] rd;
      bit w, sz, sg;
      logic [31:0] a, wd;
      int idx, nresp, ovl;

      rst = 1'b1; mem_init = 1'b1;
      req_valid = 1'b0; req_write = 1'b0; req_size = 1'b0;
      req_signed = 1'b0; req_addr = 32'b0; req_wdata = 32'b0;
      for (int i = 0; i < 64; i++) ref_mem[i] = 8'(i * 37 + 11);
      #1;
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_valid", 32'(resp_valid), 32'd0);
      chk("rst_error", 32'(resp_error), 32'd0);
      chk("rst_rdata", resp_rdata, 32'd0);
      chk("rst_strobes", {28'b0, mem_read, mem_write}, 32'd0);
      chk("rst_addr", mem_address, 32'd0);
      chk("rst_wordin", mem_word_in, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0; mem_init = 1'b0;

      txn(1, 1, 0, 32'd8, 32'hDEADBEEF, "sw8", rd);
      txn(0, 1, 0, 32'd8, 32'h0, "lw8", rd);
      chk("lw8_const", rd, 32'hDEADBEEF);
      chk("addr_held", mem_address, 32'd8);
      txn(1, 0, 0, 32'd13, 32'h000000F0, "sb13", rd);
      txn(0, 0, 1, 32'd13, 32'h0, "lbs13", rd);
      chk("lbs13_const", rd, 32'hFFFFFFF0);
      txn(0, 0, 0, 32'd13, 32'h0, "lbu13", rd);
      chk("lbu13_const", rd, 32'h000000F0);
      txn(0, 1, 0, 32'd6, 32'h0, "lw6_mis", rd);
      txn(0, 1, 0, 32'd60, 32'h0, "lw60", rd);
      txn(0, 1, 0, 32'd64, 32'h0, "lw64", rd);
      txn(1, 0, 0, 32'd63, 32'h0000005A, "sb63", rd);
      txn(0, 0, 0, 32'hFFFFFFFF, 32'h0, "lb_wrap", rd);

      // Reset while the store strobe is up.
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_size = 1'b1;
      req_signed = 1'b0; req_addr = 32'd4; req_wdata = 32'h12345678;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      chk("rstwr_strobe_on", 32'(mem_write), 32'd3);
      rst = 1'b1;
      #1;
      chk("rstwr_strobe_off", {28'b0, mem_read, mem_write}, 32'd0);
      chk("rstwr_ready", 32'(req_ready), 32'd1);
      chk("rstwr_valid", 32'(resp_valid), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rstwr_ready_rel", 32'(req_ready), 32'd1);
      txn(0, 1, 0, 32'd4, 32'h0, "rstwr_lw4", rd);

      // Four requests with req_valid held high throughout.
      qw = '{1, 0, 0, 0}; qs = '{1, 1, 0, 1}; qg = '{0, 0, 1, 0};
      qa = '{32'd20, 32'd20, 32'd21, 32'd2};
      qd = '{32'hCAFEF00D, 32'h0, 32'h0, 32'h0};
      idx = 0; nresp = 0; ovl = 0;
      for (int c = 0; c < 40 && nresp < 4; c++) begin
         @(negedge clk);
         if (mem_read != 2'b00 && mem_write != 2'b00) ovl++;
         if (resp_valid) begin
            if (nresp < idx) begin
               chk($sformatf("q%0d_err", nresp), 32'(resp_error),
                   32'(qe[nresp]));
               chk($sformatf("q%0d_rdata", nresp), resp_rdata, qr[nresp]);
            end
            nresp++;
         end
         if (idx < 4) begin
            req_valid = 1'b1; req_write = qw[idx]; req_size = qs[idx];
            req_signed = qg[idx]; req_addr = qa[idx]; req_wdata = qd[idx];
         end else begin
            req_valid = 1'b0;
         end
         if (req_valid && req_ready) begin
            model(qw[idx], qs[idx], qg[idx], qa[idx], qd[idx],
                  qe[idx], qr[idx]);
            idx++;
         end
      end
      req_valid = 1'b0;
      chk("q_accepts", 32'(idx), 32'd4);
      chk("q_resps", 32'(nresp), 32'd4);
      chk("q_ovl", 32'(ovl), 32'd0);
      chk("q_const_lw", qr[1], 32'hCAFEF00D);
      chk("q_const_lb", qr[2], 32'hFFFFFFFE);

      for (int n = 0; n < 40; n++) begin
         w = 1'($urandom()); sz = 1'($urandom()); sg = 1'($urandom());
         wd = $urandom();
         if ($urandom_range(0, 9) == 0) begin
            a = $urandom();
         end else begin
            a = 32'($urandom_range(0, 67));
            if (sz && $urandom_range(0, 3) != 0) a = a & 32'hFFFFFFFC;
         end
         txn(w, sz, sg, a, wd, $sformatf("rnd%0d", n), rd);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
